wb_trace_checker: RTL and testbench

Parametrised, self-checking writeback monitor for the single-cycle `risc_v` core bench. It replaces printing register 1 every half-period with a programmable check. It snoops the core's register-file write port and compares every architectural write against a preloaded expected trace of (register, value) pairs. It reports pass, fail or timeout with the failing entry captured. It is instantiated beside `dut_core` in the testbench and also works as a synthesizable on-chip checker.

---
 rtl/wb_trace_checker.sv | 138 +++++++++++++
 tb/tb_wb_trace_checker.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wb_trace_checker.sv
// Writeback trace checker: snoops register-file writes and compares them in order
// against a preloaded (register, value) trace, reporting pass, fail or timeout.
module wb_trace_checker #(
  parameter  int XLEN    = 32,
  parameter  int NREG    = 32,
  parameter  int DEPTH   = 64,
  parameter  int TIMEOUT = 1024,
  localparam int AW      = $clog2(NREG),
  localparam int IW      = $clog2(DEPTH),
  localparam int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load_en,
  input  logic [IW-1:0]   load_idx,
  input  logic [AW-1:0]   load_addr,
  input  logic [XLEN-1:0] load_data,
  input  logic [IW:0]     exp_count,
  input  logic            start,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [1:0]      err_code,
  output logic [IW-1:0]   err_idx,
  output logic [AW-1:0]   err_addr,
  output logic [XLEN-1:0] err_data,
  output logic [IW:0]     match_cnt
);

  // state  | meaning
  // IDLE   | after reset; trace may be loaded
  // RUN    | comparing writes against the trace
  // PASS   | all entries matched (sticky until start)
  // FAIL   | mismatch or timeout captured (sticky until start)
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  localparam logic [IW:0]   L_DEPTH   = (IW + 1)'(DEPTH);
  localparam logic [TW-1:0] L_TIMEOUT = TW'(TIMEOUT);

  logic [AW+XLEN-1:0] r_trace [DEPTH];

  logic [1:0]      r_state;
  logic [IW:0]     r_exp_cnt;
  logic [IW:0]     r_match_cnt;
  logic [TW-1:0]   r_timer;
  logic [1:0]      r_err_code;
  logic [IW-1:0]   r_err_idx;
  logic [AW-1:0]   r_err_addr;
  logic [XLEN-1:0] r_err_data;

  logic [AW-1:0]   w_exp_addr;
  logic [XLEN-1:0] w_exp_data;
  logic [IW:0]     w_match_next;
  logic [TW-1:0]   w_timer_next;
  logic [IW:0]     w_start_cnt;
  logic            w_wb_valid;

  assign {w_exp_addr, w_exp_data} = r_trace[r_match_cnt[IW-1:0]];
  assign w_match_next = r_match_cnt + 1'b1;
  assign w_timer_next = r_timer + 1'b1;
  assign w_start_cnt  = (exp_count > L_DEPTH) ? L_DEPTH : exp_count;
  assign w_wb_valid   = wb_en && (wb_addr != '0);

  // Trace contents intentionally survive reset so a trace can be rerun.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && load_en)
      r_trace[load_idx] <= {load_addr, load_data};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_exp_cnt   <= '0;
      r_match_cnt <= '0;
      r_timer     <= '0;
      r_err_code  <= 2'b00;
      r_err_idx   <= '0;
      r_err_addr  <= '0;
      r_err_data  <= '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_wb_valid) begin
            if (wb_addr != w_exp_addr || wb_data != w_exp_data) begin
              r_state    <= S_FAIL;
              r_err_code <= (wb_addr != w_exp_addr) ? 2'b01 : 2'b10;
              r_err_idx  <= r_match_cnt[IW-1:0];
              r_err_addr <= wb_addr;
              r_err_data <= wb_data;
            end else begin
              r_match_cnt <= w_match_next;
              r_timer     <= '0;
              if (w_match_next == r_exp_cnt)
                r_state <= S_PASS;
            end
          end else if (w_timer_next == L_TIMEOUT) begin
            r_state    <= S_FAIL;
            r_err_code <= 2'b11;
            r_err_idx  <= r_match_cnt[IW-1:0];
            r_err_addr <= '0;
            r_err_data <= '0;
          end else begin
            r_timer <= w_timer_next;
          end
        end
        default: begin
          // IDLE, PASS and FAIL all accept start to (re-)arm the checker
          if (start) begin
            r_state     <= (w_start_cnt == '0) ? S_PASS : S_RUN;
            r_exp_cnt   <= w_start_cnt;
            r_match_cnt <= '0;
            r_timer     <= '0;
            r_err_code  <= 2'b00;
            r_err_idx   <= '0;
            r_err_addr  <= '0;
            r_err_data  <= '0;
          end
        end
      endcase
    end
  end

  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_PASS) || (r_state == S_FAIL);
  assign pass      = (r_state == S_PASS);
  assign err_code  = r_err_code;
  assign err_idx   = r_err_idx;
  assign err_addr  = r_err_addr;
  assign err_data  = r_err_data;
  assign match_cnt = r_match_cnt;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker: table of per-cycle vectors plus
// hand-written sequences for timeout, reset mid-run and exp_count clamping.
module tb_wb_trace_checker;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int DEPTH = 8;
  localparam int TIMEOUT = 8;
  localparam int AW = 5;
  localparam int IW = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            load_en = 1'b0;
  logic [IW-1:0]   load_idx = '0;
  logic [AW-1:0]   load_addr = '0;
  logic [XLEN-1:0] load_data = '0;
  logic [IW:0]     exp_count = '0;
  logic            start = 1'b0;
  logic            wb_en = 1'b0;
  logic [AW-1:0]   wb_addr = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            busy, done, pass;
  logic [1:0]      err_code;
  logic [IW-1:0]   err_idx;
  logic [AW-1:0]   err_addr;
  logic [XLEN-1:0] err_data;
  logic [IW:0]     match_cnt;

  int n_checks = 0;
  int n_errors = 0;

  wb_trace_checker #(.XLEN(XLEN), .NREG(NREG), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .load_en(load_en), .load_idx(load_idx), .load_addr(load_addr), .load_data(load_data),
    .exp_count(exp_count), .start(start),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .busy(busy), .done(done), .pass(pass), .err_code(err_code),
    .err_idx(err_idx), .err_addr(err_addr), .err_data(err_data), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [2:0]  ld_idx;
    logic [4:0]  ld_addr;
    logic [31:0] ld_data;
    logic        st;
    logic [3:0]  cnt;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        e_busy, e_done, e_pass;
    logic [1:0]  e_code;
    logic [3:0]  e_match;
    logic [2:0]  e_idx;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic b, input logic d, input logic p,
                           input logic [1:0] c, input logic [3:0] m, input logic [2:0] i,
                           input logic [4:0] a, input logic [31:0] dt);
    check({tag, ".busy"}, 64'(busy), 64'(b));
    check({tag, ".done"}, 64'(done), 64'(d));
    check({tag, ".pass"}, 64'(pass), 64'(p));
    check({tag, ".err_code"}, 64'(err_code), 64'(c));
    check({tag, ".match_cnt"}, 64'(match_cnt), 64'(m));
    check({tag, ".err_idx"}, 64'(err_idx), 64'(i));
    check({tag, ".err_addr"}, 64'(err_addr), 64'(a));
    check({tag, ".err_data"}, 64'(err_data), 64'(dt));
  endtask

  task automatic load(input logic [2:0] idx, input logic [4:0] a, input logic [31:0] d);
    load_en = 1'b1; load_idx = idx; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_en = en; wb_addr = a; wb_data = d;
    step();
    wb_en = 1'b0;
  endtask

  initial begin
    //        ld idx addr data  st cnt en addr data  busy done pass code match idx eaddr edata
    tbl[0]  = '{1, 0, 1, 5,     1, 3, 0, 0, 0,     1, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0,     0, 3, 1, 1, 5,     1, 0, 0, 0, 1, 0, 0, 0};
    tbl[2]  = '{1, 1, 2, 77,    0, 3, 0, 0, 0,     1, 0, 0, 0, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0,     0, 3, 1, 0, 99,    1, 0, 0, 0, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0,     0, 3, 1, 2, 10,    1, 0, 0, 0, 2, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0,     0, 3, 0, 5, 3,     1, 0, 0, 0, 2, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0,     0, 3, 1, 1, 15,    0, 1, 1, 0, 3, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0,     0, 3, 1, 3, 1,     0, 1, 1, 0, 3, 0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0,     1, 3, 0, 0, 0,     1, 0, 0, 0, 0, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0,     0, 3, 1, 1, 5,     1, 0, 0, 0, 1, 0, 0, 0};
    tbl[10] = '{0, 0, 0, 0,     0, 3, 1, 2, 11,    0, 1, 0, 2, 1, 1, 2, 11};
    tbl[11] = '{0, 0, 0, 0,     0, 3, 1, 1, 15,    0, 1, 0, 2, 1, 1, 2, 11};
    tbl[12] = '{0, 0, 0, 0,     1, 3, 0, 0, 0,     1, 0, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{0, 0, 0, 0,     0, 3, 1, 3, 5,     0, 1, 0, 1, 0, 0, 3, 5};
    tbl[14] = '{0, 0, 0, 0,     1, 0, 0, 0, 0,     0, 1, 1, 0, 0, 0, 0, 0};

    step(); step();
    check_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    // entry 0 starts wrong and is fixed by the load issued together with start
    load(1, 2, 10);
    load(2, 1, 15);
    load(0, 7, 1);

    for (int v = 0; v < 15; v++) begin
      load_en = tbl[v].ld; load_idx = tbl[v].ld_idx;
      load_addr = tbl[v].ld_addr; load_data = tbl[v].ld_data;
      start = tbl[v].st; exp_count = tbl[v].cnt;
      wb_en = tbl[v].en; wb_addr = tbl[v].addr; wb_data = tbl[v].data;
      step();
      check_all($sformatf("vec%0d", v), tbl[v].e_busy, tbl[v].e_done, tbl[v].e_pass,
                tbl[v].e_code, tbl[v].e_match, tbl[v].e_idx, tbl[v].e_addr, tbl[v].e_data);
    end
    load_en = 1'b0; start = 1'b0; wb_en = 1'b0;

    // timeout: one entry, no qualifying writes; a start in RUN must be ignored
    start = 1'b1; exp_count = 1;
    step();
    start = 1'b0;
    check("to.busy_rise", 64'(busy), 64'(1));
    for (int k = 1; k <= TIMEOUT; k++) begin
      wb_en = 1'b0;
      if (k == 3) begin
        start = 1'b1; exp_count = 0;
        wb_en = 1'b1; wb_addr = 0; wb_data = 9;
      end
      step();
      start = 1'b0; wb_en = 1'b0;
      if (k < TIMEOUT) begin
        check($sformatf("to.wait%0d.busy", k), 64'(busy), 64'(1));
        check($sformatf("to.wait%0d.code", k), 64'(err_code), 64'(0));
      end else begin
        check_all("to.fire", 0, 1, 0, 3, 0, 0, 0, 0);
      end
    end

    // reset mid-run after one match, then rerun the retained trace
    start = 1'b1; exp_count = 3;
    step();
    start = 1'b0;
    wb(1, 1, 5);
    check("rst.pre_match", 64'(match_cnt), 64'(1));
    reset = 1'b0;
    step();
    reset = 1'b1;
    check_all("rst.mid_run", 0, 0, 0, 0, 0, 0, 0, 0);
    start = 1'b1; exp_count = 3;
    step();
    start = 1'b0;
    check("rerun.busy", 64'(busy), 64'(1));
    wb(1, 1, 5);
    wb(1, 2, 10);
    check("rerun.not_done", 64'(done), 64'(0));
    wb(1, 1, 15);
    check_all("rerun.pass", 0, 1, 1, 0, 3, 0, 0, 0);

    // exp_count above DEPTH clamps to DEPTH
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) load(3'(i), 5'(i + 1), 32'(100 + i));
    start = 1'b1; exp_count = 12;
    step();
    start = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wb(1, 5'(i + 1), 32'(100 + i));
      if (i == DEPTH - 2) check("clamp.busy7", 64'(busy), 64'(1));
    end
    check_all("clamp.pass", 0, 1, 1, 0, 8, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
